plot_sink: RTL
==============

PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter DEPTH, default 4, pixel FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter FRAME_PIXELS, default 3600, in-bounds pixels per frame (16 boxes x 15 x 15).
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer has a pixel on in_x/in_y/in_colour.
REQ-006 in_x  input  7  pixel column.
REQ-007 in_y  input  7  pixel row.
REQ-008 in_colour  input  3  pixel colour (111 digit, 100 box, 110 error).
REQ-009 in_ready  output  1  sink can take a pixel this cycle.
REQ-010 vga_busy  input  1  VGA adapter cannot take a write this cycle.
REQ-011 vga_x, vga_y  output  7 each  write coordinate to the VGA adapter.
REQ-012 vga_colour  output  3  write colour.
REQ-013 vga_plot  output  1  write enable; one pixel per high cycle.
REQ-014 frame_done  output  1  one-cycle pulse after the last pixel of a frame is plotted.
REQ-015 drawing  output  1  high while a frame is in progress.
REQ-016 err_oob  output  1  sticky flag: an out-of-bounds pixel was received.
REQ-017 err_colour  output  1  sticky flag: a colour 110 pixel was received.

Function
REQ-018 Transfer occurs on a rising edge where in_valid and in_ready are both high.
REQ-019 in_ready is low exactly when the FIFO holds DEPTH entries; a pop in the same cycle does not raise it.
REQ-020 In-bounds means 57<=in_x<=123 and 27<=in_y<=93; in-bounds transfers are pushed to the FIFO.
REQ-021 Out-of-bounds transfers are consumed, not pushed, not counted, and set err_oob.
REQ-022 Any transfer with in_colour 110 sets err_colour; if in-bounds it is still pushed and plotted.
REQ-023 A pop occurs on an edge where the FIFO is non-empty and vga_busy is low.
REQ-024 On a pop edge, vga_x/vga_y/vga_colour load the head entry and vga_plot goes high for the following cycle; otherwise vga_plot is low and vga_x/vga_y/vga_colour hold.
REQ-025 Latency: a pixel transferred into an empty FIFO at edge E with vga_busy low has vga_plot high in the cycle after edge E+1.
REQ-026 Pixels are plotted in transfer order; none are dropped or duplicated while vga_busy toggles.
REQ-027 The 12-bit plot counter increments on every pop and wraps to 0 on the pop that makes it FRAME_PIXELS.
REQ-028 FSM states: IDLE, DRAW, DONE.
REQ-029 IDLE->DRAW on the first in-bounds push; DRAW->DONE on the wrapping pop; DONE->IDLE after one cycle, or DONE->DRAW if an in-bounds push occurs in that cycle.
REQ-030 drawing is high in DRAW; frame_done is high only in DONE, i.e. one cycle after the final vga_plot cycle.
REQ-031 Simultaneous push and pop with FIFO non-empty leaves occupancy unchanged.

Reset
REQ-032 Reset takes effect on the next rising edge, overriding all other inputs, including mid-frame.
REQ-033 After reset: FIFO empty, plot counter 0, FSM IDLE, in_ready 1, vga_plot 0, vga_x 0, vga_y 0, vga_colour 000, frame_done 0, drawing 0, err_oob 0, err_colour 0.
REQ-034 Pixels queued when reset is asserted are discarded without being plotted.

Structure
REQ-035 The shared package holds GRID_X_MIN=57, GRID_X_MAX=123, GRID_Y_MIN=27, GRID_Y_MAX=93, the FRAME_PIXELS default and the colour codes 111/100/110.
REQ-036 The FIFO is a sub-module named pixel_fifo with its own synchronous active-high reset, push/pop/full/empty ports and a 17-bit data path.

Verification
REQ-037 Push (57,27,100) with FIFO empty and vga_busy low -> vga_plot high with vga_x=57, vga_y=27, vga_colour=100 two cycles later; drawing goes high.
REQ-038 Hold vga_busy high and push 5 pixels at DEPTH 4 -> in_ready low after the 4th push; releasing vga_busy plots all 5 in order.
REQ-039 Stream 3600 in-bounds pixels -> exactly 3600 vga_plot cycles, then frame_done high for one cycle, drawing low, and the counter back at 0.
REQ-040 Push (56,30,111), then (60,94,111) -> no plots, err_oob high and held until reset.
REQ-041 Push (60,30,110) -> plotted with vga_colour 110 and err_colour set.
REQ-042 Assert reset after 100 plots with 3 pixels queued -> no further plots; all outputs at their reset values; the next frame completes after 3600 new pixels.

Source files
------------

// File: rtl/plot_sink_pkg.sv
// rtl/plot_sink_pkg.sv - shared constants, types and helpers for the plot sink
// Purpose: grid bounds, frame size default, colour codes, pixel record and FSM
// state type shared by plot_sink and pixel_fifo.
// Ports: none (package).
package plot_sink_pkg;

  localparam logic [6:0] GRID_X_MIN = 7'd57;
  localparam logic [6:0] GRID_X_MAX = 7'd123;
  localparam logic [6:0] GRID_Y_MIN = 7'd27;
  localparam logic [6:0] GRID_Y_MAX = 7'd93;

  // 16 boxes of 15 x 15 pixels
  localparam int FRAME_PIXELS_DEFAULT = 3600;

  localparam logic [2:0] COLOUR_DIGIT = 3'b111;
  localparam logic [2:0] COLOUR_BOX   = 3'b100;
  localparam logic [2:0] COLOUR_ERROR = 3'b110;

  localparam int PIXEL_W = 17;

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic in_grid(input logic [6:0] x, input logic [6:0] y);
    return (x >= GRID_X_MIN) && (x <= GRID_X_MAX) &&
           (y >= GRID_Y_MIN) && (y <= GRID_Y_MAX);
  endfunction

endpackage

// File: rtl/plot_sink_pixel_fifo.sv
// rtl/plot_sink_pixel_fifo.sv - pixel FIFO between the producer and the VGA writer
// Purpose: DEPTH-entry first-word-fall-through FIFO of 17-bit pixel records.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   push, wr_data       write request and data (ignored when full)
//   pop, rd_data        read request (ignored when empty) and head entry
//   full, empty         occupancy status
module pixel_fifo
  import plot_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               pop,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [PIXEL_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == FULL_COUNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign rd_data   = r_mem[r_rptr];

  // Storage carries no reset: stale entries are never read while empty.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - buffers grid pixels and plots them to a VGA adapter
// Purpose: accepts pixels from a producer, drops out-of-grid ones, queues the
// rest and writes them to the VGA adapter, tracking frame progress.
// Ports:
//   clock, reset                        single clock, sync active-high reset
//   in_valid/in_ready                   producer handshake
//   in_x, in_y, in_colour               incoming pixel
//   vga_busy                            adapter back-pressure
//   vga_x, vga_y, vga_colour, vga_plot  adapter write port
//   frame_done, drawing                 frame status
//   err_oob, err_colour                 sticky error flags
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [6:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic       in_ready,
  input  logic       vga_busy,
  output logic [6:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       frame_done,
  output logic       drawing,
  output logic       err_oob,
  output logic       err_colour
);

  localparam logic [11:0] LAST_COUNT = 12'(FRAME_PIXELS - 1);

  logic        w_full;
  logic        w_empty;
  logic        w_xfer;
  logic        w_inb;
  logic        w_push;
  logic        w_pop;
  logic        w_wrap;
  pixel_t      w_wr_pixel;
  pixel_t      w_head;
  state_t      w_state_next;

  state_t      r_state;
  logic [11:0] r_plot_cnt;
  logic        r_wrap_d;
  logic [6:0]  r_vga_x;
  logic [6:0]  r_vga_y;
  logic [2:0]  r_vga_colour;
  logic        r_vga_plot;
  logic        r_err_oob;
  logic        r_err_colour;

  assign in_ready   = ~w_full;
  assign w_xfer     = in_valid & in_ready;
  assign w_inb      = in_grid(in_x, in_y);
  assign w_push     = w_xfer & w_inb;
  assign w_pop      = ~w_empty & ~vga_busy;
  assign w_wrap     = w_pop & (r_plot_cnt == LAST_COUNT);
  assign w_wr_pixel = '{x: in_x, y: in_y, colour: in_colour};

  pixel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (w_push),
    .wr_data (w_wr_pixel),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Write port: the head entry is registered on the pop edge and presented
  // with vga_plot for exactly the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_vga_plot <= w_pop;
      if (w_pop) begin
        r_vga_x      <= w_head.x;
        r_vga_y      <= w_head.y;
        r_vga_colour <= w_head.colour;
      end
    end
  end

  // Plot counter and the delayed wrap marker. The marker lines the DONE state
  // up with the cycle after the final vga_plot cycle of the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_plot_cnt <= '0;
      r_wrap_d   <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap;
      if (w_wrap) begin
        r_plot_cnt <= '0;
      end else if (w_pop) begin
        r_plot_cnt <= r_plot_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_oob    <= 1'b0;
      r_err_colour <= 1'b0;
    end else begin
      if (w_xfer && !w_inb) begin
        r_err_oob <= 1'b1;
      end
      if (w_xfer && (in_colour == COLOUR_ERROR)) begin
        r_err_colour <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_push) w_state_next = ST_DRAW;
      ST_DRAW: if (r_wrap_d) w_state_next = ST_DONE;
      ST_DONE: w_state_next = w_push ? ST_DRAW : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign frame_done = (r_state == ST_DONE);
  assign drawing    = (r_state == ST_DRAW);
  assign err_oob    = r_err_oob;
  assign err_colour = r_err_colour;

endmodule
